srrc_rx_flt: RTL and testbench

//  Receive-side square-root raised-cosine matched filter; partner to the transmit SRRC pulse shaper.

---
 rtl/srrc_pkg.sv | 51 +++++
 rtl/srrc_rx_coef_rom.sv | 18 +
 rtl/srrc_rx_flt.sv | 119 +++++++++++
 tb/tb_srrc_rx_flt.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/srrc_pkg.sv
// Shared definitions for the receive-side SRRC matched filter.
//   - sample / accumulator widths and tap geometry
//   - unique half of the symmetric coefficient table (centre tap last)
//   - FSM state encoding for the MAC sequencer
//   - saturating rescale of the accumulator back to a 1s17 sample
package srrc_pkg;

  localparam int SAMPLE_W  = 18;                     // 1s17 samples and coefficients
  localparam int FRAC_W    = 17;                     // 2^17 = 1.0
  localparam int NUM_TAPS  = 33;                     // odd, symmetric
  localparam int UNIQUE    = (NUM_TAPS + 1) / 2;     // 17 distinct coefficients
  localparam int ACC_GUARD = 5;
  localparam int PRE_W     = SAMPLE_W + 1;           // folded pair sum
  localparam int PROD_W    = PRE_W + SAMPLE_W;       // 37-bit product
  localparam int ACC_W     = 2 * SAMPLE_W + ACC_GUARD; // 41-bit accumulator
  localparam int CNT_W     = $clog2(UNIQUE);
  localparam int IDX_W     = $clog2(NUM_TAPS);

  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(UNIQUE - 1);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // b[0] multiplies the outermost tap pair, b[UNIQUE-1] is the centre tap.
  localparam sample_t SRRC_RX_COEF [UNIQUE] = '{
    -18'sd1200,  -18'sd2100,  -18'sd1500,   18'sd600,
     18'sd3300,   18'sd4600,   18'sd2800,  -18'sd2500,
    -18'sd8900,  -18'sd12400, -18'sd8200,   18'sd5400,
     18'sd25600,  18'sd47100,  18'sd64900,  18'sd77600,
     18'sd82300
  };

  // Arithmetic shift back to 1s17; clamp when the shifted value does not
  // fit in a signed 18-bit sample.
  function automatic sample_t sat_acc(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    sh = a >>> FRAC_W;
    if ((&sh[ACC_W-1:SAMPLE_W-1]) || !(|sh[ACC_W-1:SAMPLE_W-1]))
      sat_acc = sh[SAMPLE_W-1:0];
    else if (sh[ACC_W-1])
      sat_acc = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      sat_acc = {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/srrc_rx_coef_rom.sv
// Combinational coefficient ROM for the SRRC matched filter.
//   addr : tap counter of the MAC sequencer (0..UNIQUE-1)
//   coef : signed 1s17 coefficient b[addr]; zero for unused addresses
module srrc_rx_coef_rom
  import srrc_pkg::*;
(
  input  logic [CNT_W-1:0] addr,
  output sample_t          coef
);

  always_comb begin
    // NOTE: default first so every path assigns coef and no latch is inferred.
    coef = '0;
    if (addr <= LAST_TAP)
      coef = SRRC_RX_COEF[addr];
  end

endmodule

// File: rtl/srrc_rx_flt.sv
// Receive SRRC matched filter: folded symmetric 33-tap FIR, one shared
// multiplier sequenced over the 17 unique coefficients per input sample.
//   clk        : system clock
//   reset      : synchronous, active-high
//   sam_clk_en : one-cycle sample strobe, qualifies in
//   in         : signed 1s17 received sample
//   out        : signed 1s17 filtered sample, registered, holds between updates
//   out_valid  : one-cycle pulse when out updates
//   busy       : MAC sequence in progress
//   overrun    : sticky, a strobe arrived while the MAC was running
module srrc_rx_flt
  import srrc_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    sam_clk_en,
  input  sample_t in,
  output sample_t out,
  output logic    out_valid,
  output logic    busy,
  output logic    overrun
);

  sample_t                   x [NUM_TAPS];
  state_t                    state;
  logic [CNT_W-1:0]          tap_cnt;
  logic signed [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]          fwd_idx;
  logic [IDX_W-1:0]          mir_idx;
  logic signed [PRE_W-1:0]   pre;
  logic signed [PROD_W-1:0]  prod;
  sample_t                   coef;

  // Delay line. History must start from zero so the first outputs after
  // reset reflect only the new samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the tap memory is reset explicitly because stale samples would
      // leak into the first 32 outputs otherwise.
      for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
    end else if (sam_clk_en) begin
      x[0] <= in;
      for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
    end
  end

  // Pre-adder: tap k and its mirror share b[k]; the centre tap stands alone.
  assign fwd_idx = IDX_W'(tap_cnt);
  assign mir_idx = IDX_W'(NUM_TAPS - 1) - fwd_idx;

  always_comb begin
    pre = PRE_W'(x[UNIQUE-1]);
    if (tap_cnt < LAST_TAP)
      pre = PRE_W'(x[fwd_idx]) + PRE_W'(x[mir_idx]);
  end

  srrc_rx_coef_rom u_rom (
    .addr (tap_cnt),
    .coef (coef)
  );

  // The one multiplier of the datapath.
  assign prod = pre * coef;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tap_cnt   <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples the
      // pre-edge values, independent of statement order.
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sam_clk_en) begin
            state   <= ST_MAC;
            tap_cnt <= '0;
            acc     <= '0;
            busy    <= 1'b1;
          end
        end
        ST_MAC: begin
          if (sam_clk_en) begin
            // New sample mid-window: abandon this sum, restart on the new window.
            overrun <= 1'b1;
            acc     <= '0;
            tap_cnt <= '0;
          end else begin
            acc <= acc + ACC_W'(prod);
            if (tap_cnt == LAST_TAP)
              state <= ST_DONE;
            else
              tap_cnt <= tap_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          out       <= sat_acc(acc);
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
          // A strobe here is legal: start the next window straight away.
          if (sam_clk_en) begin
            state   <= ST_MAC;
            tap_cnt <= '0;
            acc     <= '0;
            busy    <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srrc_rx_flt.sv
// Self-checking bench for srrc_rx_flt: directed impulse, DC, negative
// saturation, overrun and mid-MAC reset cases, then random samples against
// a direct-form (unfolded) reference convolution.
module tb_srrc_rx_flt;

  logic               clk;
  logic               reset;
  logic               sam_clk_en;
  logic signed [17:0] smp;
  logic signed [17:0] out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  srrc_rx_flt dut (
    .clk        (clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .in         (smp),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent copy of the unique coefficients and the full 33-tap response.
  int b [17] = '{ -1200, -2100, -1500,   600,  3300,  4600,  2800, -2500,
                  -8900, -12400, -8200, 5400, 25600, 47100, 64900, 77600,
                  82300 };
  int h    [33];
  int hist [33];
  int exp_y;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_out();
    longint a = 0;
    for (int j = 0; j < 33; j++) a += longint'(h[j]) * longint'(hist[j]);
    a = a >>> 17;
    if (a > 131071)  return 131071;
    if (a < -131072) return -131072;
    return int'(a);
  endfunction

  // Entered #1 after an edge; the strobe is sampled on the next edge.
  task automatic strobe(input int v);
    sam_clk_en = 1'b1;
    smp        = 18'(v);
    for (int j = 32; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = v;
    exp_y   = model_out();
    @(posedge clk); #1;
    sam_clk_en = 1'b0;
    smp        = '0;
  endtask

  // Waits (bounded) for out_valid and checks its latency and value.
  task automatic await_out(input string tag, input int exp_lat);
    int lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " value"}, out, exp_y);
  endtask

  task automatic send(input int v, input string tag);
    strobe(v);
    await_out(tag, 18);
  endtask

  initial begin
    int cnt;
    int hand;
    logic signed [17:0] r;

    for (int j = 0; j < 33; j++) begin
      h[j]    = (j < 17) ? b[j] : b[32-j];
      hist[j] = 0;
    end

    reset      = 1'b1;
    sam_clk_en = 1'b0;
    smp        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out",       out,       0);
    check("reset out_valid", out_valid, 0);
    check("reset busy",      busy,      0);
    check("reset overrun",   overrun,   0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Impulse of 0.5: outputs walk through b[k]/2 and back, then zero.
    for (int n = 0; n < 34; n++) begin
      send((n == 0) ? 65536 : 0, "impulse");
      if (n <= 16)      hand = b[n] >>> 1;
      else if (n <= 32) hand = b[32-n] >>> 1;
      else              hand = 0;
      check("impulse hand", out, hand);
      if (n == 0) begin
        check("busy after done", busy, 0);
        @(posedge clk); #1;
        check("out_valid one cycle", out_valid, 0);
        check("out holds", out, hand);
      end
    end

    // Full-scale DC: coefficient sum exceeds 1.0, so the output clamps high.
    for (int n = 0; n < 35; n++) begin
      send(131071, "dc");
      if (n >= 32) check("dc saturated", out, 131071);
    end

    // Samples signed against the coefficients drive the sum hard negative.
    for (int n = 0; n < 33; n++)
      send((h[n] >= 0) ? -131072 : 131071, "negsat");
    check("negsat clamp", out, -131072);
    check("no overrun yet", overrun, 0);

    // Overrun: second strobe 10 cycles after the first.
    strobe(40000);
    cnt = 0;
    repeat (9) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("overrun early out_valid", cnt, 0);
    strobe(-25000);
    check("overrun set", overrun, 1);
    await_out("overrun restart", 18);
    check("overrun sticky", overrun, 1);

    // Reset asserted 8 edges into a MAC window.
    strobe(12345);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset busy",      busy,      0);
    check("midreset out",       out,       0);
    check("midreset out_valid", out_valid, 0);
    check("midreset overrun",   overrun,   0);
    reset = 1'b0;
    for (int j = 0; j < 33; j++) hist[j] = 0;
    cnt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("midreset no out_valid", cnt, 0);

    // Random full-range samples against the reference convolution.
    for (int n = 0; n < 2000; n++) begin
      r = 18'($urandom);
      send(int'(r), "random");
    end
    check("random no overrun", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
